alu_req_scheduler: RTL and testbench

//  Shares one 16-bit ALU (registered, 4-bit opcode, 32-bit result) among NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_req_scheduler.sv | 138 +++++++++++++
 tb/tb_alu_req_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcode map, legality check and
// FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_INC = 4'b1010;
   localparam logic [3:0] OP_DEC = 4'b1011;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_DEC);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or after ptr_i,
// wrapping around.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            any_o
);

   int              j;
   logic [IdxW-1:0] jx;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      jx    = '0;
      for (int k = 0; k < int'(N); k++) begin
         j  = (int'(ptr_i) + k) % int'(N);
         jx = IdxW'(j);
         if (!any_o && req_i[jx]) begin
            any_o     = 1'b1;
            gnt_o[jx] = 1'b1;
            idx_o     = jx;
         end
      end
   end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin grant, one operation in
// flight, result returned with the requester ID over a valid/ready response channel.
module alu_req_scheduler
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ALU_LAT = 2,
   localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic [4*NUM_REQ-1:0]    req_opcode_i,
   input  logic [DATA_W*NUM_REQ-1:0] req_a_i,
   input  logic [DATA_W*NUM_REQ-1:0] req_b_i,
   output logic [3:0]              alu_opcode_o,
   output logic [DATA_W-1:0]       alu_a_o,
   output logic [DATA_W-1:0]       alu_b_o,
   input  logic [31:0]             alu_result_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [IdW-1:0]          resp_id_o,
   output logic [31:0]             resp_result_o,
   output logic                    resp_err_o,
   output logic                    busy_o
);

   localparam int unsigned CntW = $clog2(ALU_LAT + 1);

   state_t            state_q, state_d;
   logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [3:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [IdW-1:0]    id_q, id_d;
   logic [CntW-1:0]   lat_cnt_q, lat_cnt_d;
   logic [31:0]       result_q, result_d;
   logic              err_q, err_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IdW-1:0]     gnt_idx;
   logic               gnt_any;
   logic [3:0]         gnt_op;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req_i (req_valid_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign gnt_op = req_opcode_i[4*gnt_idx +: 4];

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      id_d      = id_q;
      lat_cnt_d = lat_cnt_q;
      result_d  = result_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               op_d      = gnt_op;
               a_d       = req_a_i[DATA_W*gnt_idx +: DATA_W];
               b_d       = req_b_i[DATA_W*gnt_idx +: DATA_W];
               id_d      = gnt_idx;
               rr_ptr_d  = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               lat_cnt_d = '0;
               if (is_legal_op(gnt_op)) begin
                  state_d = ST_EXEC;
               end else begin
                  // Illegal ops never reach the ALU; answer immediately with an error.
                  state_d  = ST_RESP;
                  err_d    = 1'b1;
                  result_d = '0;
               end
            end
         end
         ST_EXEC: begin
            if (lat_cnt_q == CntW'(ALU_LAT - 1)) begin
               result_d = alu_result_i;
               err_d    = 1'b0;
               state_d  = ST_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         op_q      <= OP_NOP;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         lat_cnt_q <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         id_q      <= id_d;
         lat_cnt_q <= lat_cnt_d;
         result_q  <= result_d;
         err_q     <= err_d;
      end
   end

   // ALU sees NOP and zero operands whenever no operation is executing.
   assign req_ready_o   = (state_q == ST_IDLE) ? gnt : '0;
   assign alu_opcode_o  = (state_q == ST_EXEC) ? op_q : OP_NOP;
   assign alu_a_o       = (state_q == ST_EXEC) ? a_q : '0;
   assign alu_b_o       = (state_q == ST_EXEC) ? b_q : '0;
   assign resp_valid_o  = (state_q == ST_RESP);
   assign resp_id_o     = (state_q == ST_RESP) ? id_q : '0;
   assign resp_result_o = (state_q == ST_RESP) ? result_q : '0;
   assign resp_err_o    = (state_q == ST_RESP) ? err_q : 1'b0;
   assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed self-checking bench for alu_req_scheduler with a one-stage registered ALU model.
module tb_alu_req_scheduler;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_opcode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [31:0] alu_result;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_req_scheduler #(
    .NUM_REQ (4),
    .DATA_W  (16),
    .ALU_LAT (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_opcode_i  (req_opcode),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .alu_opcode_o  (alu_opcode),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_result_i  (alu_result),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_result_o (resp_result),
    .resp_err_o    (resp_err),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      OP_ADD:  return {16'd0, a} + {16'd0, b};
      OP_SUB:  return {16'd0, a} - {16'd0, b};
      OP_MUL:  return {16'd0, a} * {16'd0, b};
      OP_AND:  return {16'd0, a & b};
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk) alu_result <= alu_f(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    req_valid[i]         = v;
    req_opcode[4*i +: 4] = op;
    req_a[16*i +: 16]    = a;
    req_b[16*i +: 16]    = b;
  endtask

  logic [3:0] exp_gnt;

  initial begin
    #100000;
    bad++;
    $error("FAIL timeout: wait expired before test completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    reset = 1'b0;
    tick();

    // T1: single ADD from requester 0
    set_req(0, 1'b1, OP_ADD, 16'd10, 16'd5);
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_exec", 32'(req_ready), 32'd0);
    chk("t1_alu_op", 32'(alu_opcode), 32'(OP_ADD));
    chk("t1_alu_a", 32'(alu_a), 32'd10);
    tick();
    chk("t1_not_yet", 32'(resp_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(resp_valid), 32'd1);
    chk("t1_id", 32'(resp_id), 32'd0);
    chk("t1_result", resp_result, 32'd15);
    chk("t1_err", 32'(resp_err), 32'd0);
    chk("t1_alu_op_exit", 32'(alu_opcode), 32'(OP_NOP));
    resp_ready = 1'b1;
    tick();
    chk("t1_done", 32'(resp_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    resp_ready = 1'b0;

    // T2: fairness from a fresh pointer
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, OP_SUB, 16'd15, 16'd7);
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      chk("t2_grant", 32'(req_ready), 32'(exp_gnt));
      tick();
      tick();
      tick();
      chk("t2_valid", 32'(resp_valid), 32'd1);
      chk("t2_id", 32'(resp_id), 32'(k % 4));
      chk("t2_result", resp_result, 32'd8);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    chk("t2_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);

    // T3: backpressure on MUL, competing request must wait
    set_req(1, 1'b1, OP_MUL, 16'd10, 16'd3);
    set_req(2, 1'b1, OP_ADD, 16'd1, 16'd1);
    #1;
    chk("t3_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(resp_valid), 32'd1);
      chk("t3_hold_result", resp_result, 32'd30);
      chk("t3_hold_id", 32'(resp_id), 32'd1);
      chk("t3_no_grant", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("t3_released", 32'(resp_valid), 32'd0);
    chk("t3_next_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    chk("t3_r2_id", 32'(resp_id), 32'd2);
    chk("t3_r2_result", resp_result, 32'd2);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // T4: illegal opcode answered next edge without touching the ALU
    set_req(2, 1'b1, 4'b1111, 16'd4, 16'd4);
    #1;
    chk("t4_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    chk("t4_alu_op", 32'(alu_opcode), 32'd0);
    chk("t4_valid", 32'(resp_valid), 32'd1);
    chk("t4_id", 32'(resp_id), 32'd2);
    chk("t4_err", 32'(resp_err), 32'd1);
    chk("t4_result", resp_result, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // T5: pointer wraps from 3 to requester 1
    chk("t5_ptr_before", 32'(dut.rr_ptr_q), 32'd3);
    set_req(1, 1'b1, OP_ADD, 16'd1, 16'd2);
    #1;
    chk("t5_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    chk("t5_ptr_after", 32'(dut.rr_ptr_q), 32'd2);
    tick();
    tick();
    chk("t5_result", resp_result, 32'd3);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // T6: reset during EXEC drops the operation
    set_req(2, 1'b1, OP_AND, 16'hFF00, 16'h0FF0);
    #1;
    chk("t6_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    chk("t6_alu_op", 32'(alu_opcode), 32'(OP_AND));
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(resp_valid), 32'd0);
    chk("t6_rst_alu_op", 32'(alu_opcode), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_resp", 32'(resp_valid), 32'd0);
    end
    set_req(3, 1'b1, OP_ADD, 16'd7, 16'd8);
    #1;
    chk("t6_r3_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0;
    tick();
    tick();
    chk("t6_r3_valid", 32'(resp_valid), 32'd1);
    chk("t6_r3_id", 32'(resp_id), 32'd3);
    chk("t6_r3_result", resp_result, 32'd15);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
